// File: rtl/mips_muldiv_unit_pkg.sv
// Shared op codes and FSM state encodings for the multiply/divide unit.
// The ALU decoder also imports this package.
package muldiv_defs;

  typedef enum logic [2:0] {
    OP_MULTU = 3'b000,
    OP_DIVU  = 3'b001,
    OP_MULT  = 3'b010,
    OP_DIV   = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } muldiv_state_e;

  function automatic logic is_muldiv_op(input logic [2:0] op);
    return op inside {OP_MULTU, OP_DIVU, OP_MULT, OP_DIV};
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Core-side port bundle of the multiply/divide unit; the core drives the
// master side, the unit sits on the slave side.
interface mips_muldiv_unit_if
  import muldiv_defs::*;
#(
  parameter int WIDTH = 32
) ();

  // start is a single-cycle request sampled on the rising edge whenever busy==0;
  // while busy==1 start is ignored. done pulses for one cycle with hi/lo already
  // updated and divzero valid. MTHI/MTLO complete on the start edge without done.
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             divzero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  muldiv_state_e    dbg_state;

  modport master (
    output start, op, a, b,
    input  busy, done, divzero, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, divzero, hi, lo, dbg_state
  );

endinterface

// File: rtl/mips_muldiv_unit_step.sv
// One iteration of the unit: shift-add multiply or restoring shift-subtract
// divide on the {acc, opnd} pair. Purely combinational.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_opnd,
  input  logic [WIDTH-1:0] i_mcand,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_opnd
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_add;
  logic [WIDTH:0] w_rem;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  always_comb begin
    w_sum  = {1'b0, i_acc} + {1'b0, i_mcand};
    w_add  = i_opnd[0] ? w_sum : {1'b0, i_acc};
    // Partial remainder shifted left, pulling in the next dividend bit.
    w_rem  = {i_acc, i_opnd[WIDTH-1]};
    w_ge   = (w_rem >= {1'b0, i_mcand});
    w_diff = w_rem - {1'b0, i_mcand};
    if (i_is_div) begin
      o_acc  = w_ge ? w_diff[WIDTH-1:0] : w_rem[WIDTH-1:0];
      o_opnd = {i_opnd[WIDTH-2:0], w_ge};
    end else begin
      o_acc  = w_add[WIDTH:1];
      o_opnd = {w_add[0], i_opnd[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO, one bit per cycle.
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise they behave as MULTU/DIVU.
module mips_muldiv_unit
  import muldiv_defs::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] HILO_RESET = '0
) (
  input  logic                clk,
  input  logic                reset,
  mips_muldiv_unit_if.slave   bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  muldiv_state_e    r_state, w_state_n;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc, r_opnd, r_mcand, r_a, r_hi, r_lo;
  logic             r_is_div, r_b_zero, r_divzero;
  logic [WIDTH-1:0] w_acc_n, w_opnd_n, w_a_mag, w_b_mag, w_hi_res, w_lo_res;
  logic             w_start_md, w_start_any, w_last;

  assign w_start_any = bus.start && (r_state != ST_RUN);
  assign w_start_md  = w_start_any && is_muldiv_op(bus.op);
  assign w_last      = (r_state == ST_RUN) && (r_cnt == CNT_LAST);

`ifdef MULDIV_SIGNED_EN
  localparam logic [WIDTH-1:0]   ONE  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2 = {{(2*WIDTH-1){1'b0}}, 1'b1};
  logic             w_signed_op, w_sa, w_sb;
  logic             r_neg_q, r_neg_r;
  logic [2*WIDTH-1:0] w_prod_neg;

  assign w_signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign w_sa        = w_signed_op && bus.a[WIDTH-1];
  assign w_sb        = w_signed_op && bus.b[WIDTH-1];
  assign w_a_mag     = w_sa ? (~bus.a + ONE) : bus.a;
  assign w_b_mag     = w_sb ? (~bus.b + ONE) : bus.b;
`else
  assign w_a_mag = bus.a;
  assign w_b_mag = bus.b;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .i_mcand  (r_mcand),
    .o_acc    (w_acc_n),
    .o_opnd   (w_opnd_n)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: w_state_n = w_start_md ? ST_RUN : ST_IDLE;
      ST_RUN:           if (w_last) w_state_n = ST_DONE;
      default:          w_state_n = ST_IDLE;
    endcase
  end

  // Both ops leave the high half in acc and the low half in opnd.
  always_comb begin
    w_hi_res = w_acc_n;
    w_lo_res = w_opnd_n;
`ifdef MULDIV_SIGNED_EN
    w_prod_neg = ~{w_acc_n, w_opnd_n} + ONE2;
    if (!r_is_div && r_neg_q) {w_hi_res, w_lo_res} = w_prod_neg;
    if (r_is_div && r_neg_q)  w_lo_res = ~w_opnd_n + ONE;
    if (r_is_div && r_neg_r)  w_hi_res = ~w_acc_n + ONE;
`endif
    if (r_is_div && r_b_zero) begin
      w_hi_res = r_a;
      w_lo_res = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_mcand  <= '0;
      r_a      <= '0;
      r_is_div <= 1'b0;
      r_b_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else if (w_start_md) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= w_a_mag;
      r_mcand  <= w_b_mag;
      r_a      <= bus.a;
      r_is_div <= bus.op[0];
      r_b_zero <= (bus.b == '0);
`ifdef MULDIV_SIGNED_EN
      r_neg_q  <= w_sa ^ w_sb;
      r_neg_r  <= w_sa;
`endif
    end else if (r_state == ST_RUN) begin
      r_cnt  <= r_cnt + CNT_ONE;
      r_acc  <= w_acc_n;
      r_opnd <= w_opnd_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi      <= HILO_RESET;
      r_lo      <= HILO_RESET;
      r_divzero <= 1'b0;
    end else begin
      r_divzero <= 1'b0;
      if (w_last) begin
        r_hi      <= w_hi_res;
        r_lo      <= w_lo_res;
        r_divzero <= r_is_div && r_b_zero;
      end else if (w_start_any) begin
        if (bus.op == OP_MTHI) r_hi <= bus.a;
        if (bus.op == OP_MTLO) r_lo <= bus.a;
      end
    end
  end

  assign bus.busy      = (r_state == ST_RUN);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.divzero   = r_divzero;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit at WIDTH=32: directed vectors, back-to-back
// issue, MTHI/MTLO, mid-operation reset and random mul/div traffic.
module tb_mips_muldiv_unit;
  import muldiv_defs::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_muldiv_unit_if #(.WIDTH(W)) bus ();

  mips_muldiv_unit #(.WIDTH(W), .HILO_RESET('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [2*W:0] exp_q[$];
  logic [2*W:0] mon_exp;
  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  task automatic check(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {divzero, hi, lo} from plain SV arithmetic.
  function automatic logic [2*W:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic sgn;
    logic [2*W-1:0] p;
    logic [W-1:0] q, r;
`ifdef MULDIV_SIGNED_EN
    sgn = op[1];
`else
    sgn = 1'b0;
`endif
    if (!op[0]) begin
      if (sgn) p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      else     p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return {1'b0, p};
    end
    if (b == '0) return {1'b1, a, {W{1'b1}}};
    if (sgn) begin
      if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) return {1'b0, {W{1'b0}}, a};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, r, q};
  endfunction

  // Scoreboard consumer: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {bus.divzero, bus.hi, bus.lo}, mon_exp);
      end
    end
  end

  task automatic issue_exp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W:0] e);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (is_muldiv_op(op)) exp_q.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue_exp(op, a, b, model(op, a, b));
  endtask

  task automatic wait_done(output int busy_cyc, output int n_cyc);
    busy_cyc = 0;
    n_cyc    = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cyc++;
      if (bus.busy) busy_cyc++;
      if (bus.done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int bc, nc, d0;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;

    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_divzero", bus.divzero, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_state", bus.dbg_state, ST_IDLE);

    issue_exp(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFE, 32'h00000001});
    wait_done(bc, nc);
    check("multu_busy_cycles", bc, 32);
    issue_exp(OP_DIVU, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14});
    wait_done(bc, nc);
    issue_exp(OP_DIVU, 32'd5, 32'd0, {1'b1, 32'd5, 32'hFFFFFFFF});
    wait_done(bc, nc);
    check("divzero_pulse", bus.divzero, 1);

`ifdef MULDIV_SIGNED_EN
    issue_exp(OP_MULT, 32'hFFFFFFFD, 32'd7, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB});
    wait_done(bc, nc);
    issue_exp(OP_DIV, 32'hFFFFFFF9, 32'd2, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
    wait_done(bc, nc);
    issue_exp(OP_DIV, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h0, 32'h80000000});
    wait_done(bc, nc);
`else
    issue_exp(OP_MULT, 32'hFFFFFFFD, 32'd7, {1'b0, 32'h00000006, 32'hFFFFFFEB});
    wait_done(bc, nc);
    issue_exp(OP_DIV, 32'hFFFFFFF9, 32'd2, {1'b0, 32'h00000001, 32'h7FFFFFFC});
    wait_done(bc, nc);
    issue_exp(OP_DIV, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h80000000, 32'h0});
    wait_done(bc, nc);
`endif

    // Issued in the DONE cycle of the previous op.
    issue_exp(OP_MULTU, 32'd3, 32'd5, {1'b0, 32'd0, 32'd15});
    wait_done(bc, nc);
    check("b2b_gap", nc, 33);
    @(negedge clk);
    check("divzero_cleared", bus.divzero, 0);

    d0 = n_done;
    issue(OP_MTHI, 32'h1234, 32'd0);
    check("mthi_hi", bus.hi, 32'h1234);
    check("mthi_busy", bus.busy, 0);
    @(negedge clk);
    issue(OP_MTLO, 32'h5678, 32'd0);
    check("mtlo_lo", bus.lo, 32'h5678);
    issue(3'b110, 32'hAAAA, 32'd1);
    check("undef_op_state", bus.dbg_state, ST_IDLE);
    repeat (3) @(negedge clk);
    check("mt_no_done", n_done, d0);

    issue_exp(OP_MULTU, 32'h00010000, 32'h00030000, {1'b0, 32'd3, 32'd0});
    repeat (5) @(negedge clk);
    issue(OP_MTLO, 32'hDEAD, 32'd0);
    check("run_mtlo_lo", bus.lo, 32'h5678);
    check("run_hi_kept", bus.hi, 32'h1234);
    check("run_busy", bus.busy, 1);
    wait_done(bc, nc);

    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = '1;
        default: rb = $urandom;
      endcase
      issue(rop, ra, rb);
      wait_done(bc, nc);
      check("rand_busy_cycles", bc, 32);
    end

    @(negedge clk);
    issue(OP_MULTU, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    d0 = n_done;
    check("midrst_busy", bus.busy, 0);
    check("midrst_hi", bus.hi, 0);
    check("midrst_lo", bus.lo, 0);
    check("midrst_state", bus.dbg_state, ST_IDLE);
    repeat (40) @(negedge clk);
    check("midrst_no_done", n_done, d0);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
